// File: rtl/move_frame_tx.sv
// move_frame_tx: serializes accepted Connect6 stone placements into a
// byte-framed message on an 8-bit valid/ready stream.
// Frame: SOF, count, x_1, y_1, [x_2, y_2], [checksum].
// Optional feature macro: MOVE_TX_CSUM_EN appends an XOR checksum byte.
`timescale 1ns/1ps
module move_frame_tx #(
  parameter int          BOARD_SIZE = 19,
  parameter logic [7:0]  SOF_BYTE   = 8'hC6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic       first_move,
  input  logic [5:0] x_1,
  input  logic [5:0] y_1,
  input  logic [5:0] x_2,
  input  logic [5:0] y_2,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       err_range,
  output logic [7:0] frame_cnt
);

  // state | meaning
  // IDLE  | waiting for a move pair, mv_ready high
  // SOF   | sending start-of-frame marker
  // CNT   | sending stone count (1 or 2)
  // X1    | sending first stone x
  // Y1    | sending first stone y
  // X2    | sending second stone x
  // Y2    | sending second stone y
  // CSUM  | sending XOR checksum (checksum build only)
  typedef enum logic [2:0] {
    IDLE, SOF, CNT, X1, Y1, X2, Y2
`ifdef MOVE_TX_CSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [6:0] BS = 7'(BOARD_SIZE);

  state_t     state, state_nxt;
  logic [5:0] x1_q, y1_q, x2_q, y2_q;
  logic       first_q;
  logic       accept, bad, hs;

  assign mv_ready = (state == IDLE) && !rst;
  assign accept   = mv_valid && mv_ready;
  assign hs       = tx_valid && tx_ready;

  // Second stone is only range-checked when it is actually sent.
  assign bad = ({1'b0, x_1} >= BS) || ({1'b0, y_1} >= BS) ||
               (!first_move && (({1'b0, x_2} >= BS) || ({1'b0, y_2} >= BS)));

`ifdef MOVE_TX_CSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every byte handshaken so far in the current frame.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) csum_q <= '0;
    else if (hs)              csum_q <= csum_q ^ tx_data;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and byte mux; outputs depend on state only, so they hold
  // steady while the sink stalls.
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    case (state)
      IDLE: if (accept && !bad) state_nxt = SOF;
      SOF: begin
        tx_valid = 1'b1;
        tx_data  = SOF_BYTE;
        if (tx_ready) state_nxt = CNT;
      end
      CNT: begin
        tx_valid = 1'b1;
        tx_data  = first_q ? 8'd1 : 8'd2;
        if (tx_ready) state_nxt = X1;
      end
      X1: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, x1_q};
        if (tx_ready) state_nxt = Y1;
      end
      Y1: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, y1_q};
        if (first_q) begin
`ifdef MOVE_TX_CSUM_EN
          if (tx_ready) state_nxt = CSUM;
`else
          tx_last = 1'b1;
          if (tx_ready) state_nxt = IDLE;
`endif
        end else if (tx_ready) begin
          state_nxt = X2;
        end
      end
      X2: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, x2_q};
        if (tx_ready) state_nxt = Y2;
      end
      Y2: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, y2_q};
`ifdef MOVE_TX_CSUM_EN
        if (tx_ready) state_nxt = CSUM;
`else
        tx_last = 1'b1;
        if (tx_ready) state_nxt = IDLE;
`endif
      end
`ifdef MOVE_TX_CSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_last  = 1'b1;
        if (tx_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Move capture, range-error pulse and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
      frame_cnt <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      first_q   <= 1'b0;
    end else begin
      err_range <= accept && bad;
      if (accept) begin
        x1_q    <= x_1;
        y1_q    <= y_1;
        x2_q    <= x_2;
        y2_q    <= y_2;
        first_q <= first_move;
      end
      if (hs && tx_last) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
